// File: rtl/msg_sequencer.sv
// msg_sequencer: plays a fixed-length message from a registered character
// source into a serial transmitter with a strobe/ready handshake.
// Optional looping is compiled in with the MSG_SEQ_REPEAT_EN macro. Without
// it, the block returns to IDLE after every message and i_repeat is ignored.
module msg_sequencer #(
    parameter int MSG_LEN    = 16,   // characters per message, 1..256
    parameter int SRC_LAT    = 1,    // source latency after a step/rewind, 1..4
    parameter int GAP_CYCLES = 0     // idle cycles after each message, 0..65535
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic       i_repeat,
    input  logic       i_tx_ready,
    input  logic [7:0] i_src_data,
    output logic       o_src_rst,
    output logic       o_src_adv,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_data,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_STEP = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    localparam logic [CW-1:0] LAST_IDX  = CW'(MSG_LEN - 1);
    localparam logic [2:0]    WAIT_LAST = 3'(SRC_LAT - 1);
    localparam logic [15:0]   GAP_LAST  = 16'(GAP_CYCLES - 1);

    logic [2:0]    state_reg, state_next;
    logic          first_reg;
    logic [CW-1:0] count_reg;
    logic [2:0]    wait_reg;
    logic [15:0]   gap_reg;
    logic          tx_stb_reg;
    logic [7:0]    tx_data_reg;
    logic          done_reg;
    logic          again;

    // Whether the end of a message loops straight into a new one
`ifdef MSG_SEQ_REPEAT_EN
    assign again = i_repeat;
`else
    logic unused_repeat;
    assign unused_repeat = i_repeat;
    assign again = 1'b0;
`endif

    // Next-state selection
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (i_go) state_next = S_STEP;
            S_STEP: state_next = S_WAIT;
            S_WAIT: if (wait_reg == WAIT_LAST) state_next = S_LOAD;
            S_LOAD: state_next = S_SEND;
            S_SEND: begin
                if (i_tx_ready) begin
                    if (count_reg != LAST_IDX)
                        state_next = S_STEP;
                    else if (GAP_CYCLES > 0)
                        state_next = S_GAP;
                    else
                        state_next = again ? S_STEP : S_IDLE;
                end
            end
            S_GAP: if (gap_reg == GAP_LAST) state_next = again ? S_STEP : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, counters and the registered transmit strobe/data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            first_reg   <= 1'b0;
            count_reg   <= '0;
            wait_reg    <= '0;
            gap_reg     <= '0;
            tx_stb_reg  <= 1'b0;
            tx_data_reg <= 8'h00;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_go) begin
                        first_reg <= 1'b1;
                        count_reg <= '0;
                    end
                end
                S_STEP: wait_reg <= '0;
                S_WAIT: wait_reg <= wait_reg + 3'd1;
                S_LOAD: begin
                    tx_data_reg <= i_src_data;
                    tx_stb_reg  <= 1'b1;
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        tx_stb_reg <= 1'b0;
                        if (count_reg != LAST_IDX) begin
                            count_reg <= count_reg + 1'b1;
                            first_reg <= 1'b0;
                        end else begin
                            // Prime for a rewind in case the message loops
                            done_reg  <= 1'b1;
                            gap_reg   <= '0;
                            count_reg <= '0;
                            first_reg <= 1'b1;
                        end
                    end
                end
                S_GAP: gap_reg <= gap_reg + 16'd1;
                default: ;
            endcase
        end
    end

    assign o_src_rst = (state_reg == S_STEP) &&  first_reg;
    assign o_src_adv = (state_reg == S_STEP) && !first_reg;
    assign o_tx_stb  = tx_stb_reg;
    assign o_tx_data = tx_data_reg;
    assign o_busy    = (state_reg != S_IDLE);
    assign o_done    = done_reg;

endmodule

// File: tb/tb_msg_sequencer.sv
// Testbench for msg_sequencer: three instances (defaults, GAP_CYCLES=10,
// MSG_LEN=1/SRC_LAT=3), each fed by a behavioural character source.
module tb_msg_sequencer;

`ifdef MSG_SEQ_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, go, rep, rdy;
    logic [2:0] src_rst, src_adv, stb, busy, done;
    logic [7:0] src_data [3];
    logic [7:0] tx_data  [3];

    logic [7:0]  msg [16];
    logic [7:0]  idx [3]   = '{default: 8'd0};
    int unsigned since [3] = '{default: 0};

    int checks   = 0;
    int failures = 0;

    msg_sequencer u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_go(go[0]), .i_repeat(rep[0]),
        .i_tx_ready(rdy[0]), .i_src_data(src_data[0]),
        .o_src_rst(src_rst[0]), .o_src_adv(src_adv[0]), .o_tx_stb(stb[0]),
        .o_tx_data(tx_data[0]), .o_busy(busy[0]), .o_done(done[0]));

    msg_sequencer #(.GAP_CYCLES(10)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_go(go[1]), .i_repeat(rep[1]),
        .i_tx_ready(rdy[1]), .i_src_data(src_data[1]),
        .o_src_rst(src_rst[1]), .o_src_adv(src_adv[1]), .o_tx_stb(stb[1]),
        .o_tx_data(tx_data[1]), .o_busy(busy[1]), .o_done(done[1]));

    msg_sequencer #(.MSG_LEN(1), .SRC_LAT(3)) u_dut2 (
        .i_clk(clk), .i_rst(rst[2]), .i_go(go[2]), .i_repeat(rep[2]),
        .i_tx_ready(rdy[2]), .i_src_data(src_data[2]),
        .o_src_rst(src_rst[2]), .o_src_adv(src_adv[2]), .o_tx_stb(stb[2]),
        .o_tx_data(tx_data[2]), .o_busy(busy[2]), .o_done(done[2]));

    // Source model: index moves on a pulse, data valid SRC_LAT wait cycles later
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (src_rst[k]) begin
                idx[k] <= 8'd0; since[k] <= 0;
            end else if (src_adv[k]) begin
                idx[k] <= idx[k] + 8'd1; since[k] <= 0;
            end else if (since[k] < 100) begin
                since[k] <= since[k] + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            src_data[k] = (since[k] >= ((k == 2) ? 3 : 1)) ? msg[idx[k][3:0]] : 8'hEE;
        end
    end

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic       go;
        logic       rdy;
        logic       stb;
        logic [7:0] data;
        logic       srst;
        logic       sadv;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vt [70];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        string s;
        int n, done_cyc;
        logic [7:0] got [16];
        bit seen;

        s = " Hello, world!\r\n";
        for (int i = 0; i < 16; i++) msg[i] = s[i];

        rst = 3'b111; go = 3'b000; rdy = 3'b111;
        rep = {1'b0, 1'b1, !REP};

        // Reset state
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_stb",  k, stb[k], 0);
            chk("rst_data", k, tx_data[k], 8'h00);
            chk("rst_srst", k, src_rst[k], 0);
            chk("rst_sadv", k, src_adv[k], 0);
            chk("rst_busy", k, busy[k], 0);
            chk("rst_done", k, done[k], 0);
        end
        @(posedge clk); #1 rst = 3'b000;

        // Table: full message, ready high, second go at cycle 20 ignored
        for (int c = 0; c < 70; c++) begin
            vt[c].go   = (c == 0) || (c == 20);
            vt[c].rdy  = 1'b1;
            vt[c].stb  = (c >= 4) && (c <= 64) && (c % 4 == 0);
            vt[c].data = (c >= 4) ? msg[((c - 4) / 4) % 16] : 8'h00;
            vt[c].srst = (c == 1);
            vt[c].sadv = (c >= 5) && (c <= 61) && (c % 4 == 1);
            vt[c].busy = (c >= 1) && (c <= 64);
            vt[c].done = (c == 65);
        end
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            go[0] = vt[c].go; rdy[0] = vt[c].rdy;
            @(negedge clk);
            chk("msg_stb",  c, stb[0], vt[c].stb);
            if (vt[c].stb) chk("msg_data", c, tx_data[0], vt[c].data);
            chk("msg_srst", c, src_rst[0], vt[c].srst);
            chk("msg_sadv", c, src_adv[0], vt[c].sadv);
            chk("msg_busy", c, busy[0], vt[c].busy);
            chk("msg_done", c, done[0], vt[c].done);
        end

        // Backpressure on the 3rd character
        n = 0; done_cyc = -1;
        for (int c = 0; c < 150 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            go[0] = (c == 0); rdy[0] = !(c >= 12 && c <= 16);
            @(negedge clk);
            if (c >= 12 && c <= 16) begin
                chk("bp_stb",  c, stb[0], 1);
                chk("bp_data", c, tx_data[0], msg[2]);
            end
            if (c >= 12 && c <= 17) chk("bp_no_adv", c, src_adv[0], 0);
            if (c == 18) chk("bp_adv", c, src_adv[0], 1);
            if (stb[0] && rdy[0] && n < 16) begin got[n] = tx_data[0]; n++; end
            if (done[0]) done_cyc = c;
        end
        rdy[0] = 1'b1;
        chk("bp_done_cycle", 0, done_cyc, 70);
        chk("bp_count", 0, n, 16);
        for (int i = 0; i < 16; i++) chk("bp_byte", i, got[i], msg[i]);

        // Reset during the 7th character, then restart
        @(posedge clk); #1;
        for (int c = 0; c <= 28; c++) begin
            @(posedge clk); #1;
            go[0] = (c == 0);
            @(negedge clk);
        end
        chk("mid_stb",  28, stb[0], 1);
        chk("mid_data", 28, tx_data[0], msg[6]);
        #1 rst[0] = 1'b1;
        #1;
        chk("ar_stb",  28, stb[0], 0);
        chk("ar_data", 28, tx_data[0], 8'h00);
        chk("ar_srst", 28, src_rst[0], 0);
        chk("ar_sadv", 28, src_adv[0], 0);
        chk("ar_busy", 28, busy[0], 0);
        chk("ar_done", 28, done[0], 0);
        @(posedge clk); #1 rst[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 0, done[0], 0);
        seen = 1'b0;
        for (int c = 0; c < 120 && !seen; c++) begin
            @(posedge clk); #1;
            go[0] = (c == 0);
            @(negedge clk);
            if (c == 1) chk("rs_srst", c, src_rst[0], 1);
            if (c == 4) begin
                chk("rs_stb", c, stb[0], 1);
                chk("rs_data", c, tx_data[0], msg[0]);
            end
            if (done[0]) begin seen = 1'b1; chk("rs_done_cycle", c, c, 65); end
        end
        chk("rs_done_seen", 0, seen, 1);

        // GAP_CYCLES=10 with repeat request
        for (int c = 0; c <= 90; c++) begin
            @(posedge clk); #1;
            go[1] = (c == 0);
            @(negedge clk);
            chk("gap_busy", c, busy[1], REP ? (c >= 1) : (c >= 1 && c <= 74));
            chk("gap_done", c, done[1], c == 65);
            chk("gap_srst", c, src_rst[1], (c == 1) || (REP && c == 75));
            chk("gap_stb",  c, stb[1], ((c >= 4) && (c <= 64) && (c % 4 == 0)) ||
                                      (REP && c >= 78 && ((c - 78) % 4 == 0)));
            if (stb[1]) chk("gap_data", c, tx_data[1], msg[(((c >= 78) ? c - 78 : c - 4) / 4) % 16]);
        end
        rep[1] = 1'b0;

        // MSG_LEN=1, SRC_LAT=3
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk); #1;
            go[2] = (c == 0);
            @(negedge clk);
            chk("one_stb",  c, stb[2], c == 6);
            if (c == 6) chk("one_data", c, tx_data[2], msg[0]);
            chk("one_srst", c, src_rst[2], c == 1);
            chk("one_sadv", c, src_adv[2], 0);
            chk("one_busy", c, busy[2], c >= 1 && c <= 6);
            chk("one_done", c, done[2], c == 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_sequencer.md
# msg_sequencer

Controller that plays a fixed-length message out of the registered character source into the serial transmitter. On a start request it rewinds the source, steps it one entry per character, registers each character, and offers it to the transmitter via a strobe/ready handshake. An optional idle gap separates messages; with repeat compiled in, it loops indefinitely.

## Interface
- `MSG_LEN`, 16: characters per message, 1..256; entries 0..MSG_LEN-1 of the source.
- `SRC_LAT`, 1: wait cycles between a step/rewind pulse and the cycle in which `i_src_data` is valid, 1..4.
- `GAP_CYCLES`, 0: idle cycles after the last character of a message, 0..65535.
- `i_clk` in 1: single clock, all logic rising-edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_go` in 1: start request, sampled only in IDLE.
- `i_repeat` in 1: loop request (used only with `MSG_SEQ_REPEAT_EN`).
- `i_tx_ready` in 1: transmitter can accept a character this cycle.
- `i_src_data` in 8: registered character from the source.
- `o_src_rst` out 1: one-cycle rewind pulse to the source (index to 0).
- `o_src_adv` out 1: one-cycle step pulse to the source (index +1).
- `o_tx_stb` out 1: character valid.
- `o_tx_data` out 8: character, stable while `o_tx_stb` is high.
- `o_busy` out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse after the last character of a message is accepted.

## Operation
- States: IDLE, STEP, WAIT, LOAD, SEND, GAP.
- IDLE: `i_go`=1 -> STEP with first=1, char count=0.
- STEP (1 cycle): asserts `o_src_rst` if first, else `o_src_adv`; -> WAIT.
- WAIT (SRC_LAT cycles, own counter) -> LOAD.
- LOAD (1 cycle): `o_tx_data` <= `i_src_data`, `o_tx_stb` <= 1; -> SEND.
- SEND: holds `o_tx_stb`/`o_tx_data` until `i_tx_ready`=1 (accept). On accept `o_tx_stb` <= 0:
  - count < MSG_LEN-1: count+1, first=0, -> STEP.
  - count == MSG_LEN-1: `o_done` pulse next cycle; -> GAP if GAP_CYCLES>0, else end-of-message decision.
- GAP: counts GAP_CYCLES cycles; then end-of-message decision.
- End-of-message decision: IDLE, or STEP with first=1 when repeat is active (see Configuration).
- `i_go` outside IDLE ignored; no abort input.
- Counters: char count `$clog2(MSG_LEN)` bits, min 1; gap counter 16 bits; no wrap reachable.
- `o_src_rst` and `o_src_adv` never both high; at most one per character.

## Timing
- Reset (async, `i_rst`=1): state IDLE, all counters 0, `o_tx_stb`=0, `o_tx_data`=8'h00, `o_src_rst`=0, `o_src_adv`=0, `o_busy`=0, `o_done`=0.
- Reset mid-message: immediate return to IDLE, strobe dropped, no `o_done`; the next `i_go` restarts at entry 0.
- `i_go` sampled at edge N: STEP in cycle N+1, first `o_tx_stb` in cycle N+3+SRC_LAT.
- Per character with `i_tx_ready` held high: 3+SRC_LAT cycles (4 at defaults).
- `o_done` high exactly one cycle, the cycle after the final accept; `o_busy` drops on return to IDLE.
- `i_tx_ready` high while `o_tx_stb` low has no effect.

## Configuration
- `MSG_SEQ_REPEAT_EN` defined: at the end-of-message decision, `i_repeat`=1 -> STEP with first=1 (rewind, new message, `o_busy` stays high); `i_repeat`=0 -> IDLE.
- Not defined: `i_repeat` ignored; always -> IDLE after each message.

## Test plan
- Defaults, ready tied high, source model with entries "` Hello, world!\r\n`", `i_go` pulse at cycle 0: `o_src_rst` at cycle 1; strobes at cycles 4,8,...,64 carrying those 16 bytes in order; `o_done` at cycle 65; `o_busy` low from cycle 65.
- Backpressure: `i_tx_ready` low for 5 cycles when the 3rd character is offered: `o_tx_stb`/`o_tx_data`="e" held stable all 5 cycles; no `o_src_adv` until accept; message otherwise intact.
- GAP_CYCLES=10, repeat compiled in, `i_repeat`=1: after `o_done`, 10 idle cycles, then `o_src_rst` and message replays from entry 0; `o_busy` never drops.
- Repeat compiled out, `i_repeat`=1: block returns to IDLE after one message; a second `i_go` during the message is ignored.
- `i_rst` asserted during the 7th character: all outputs to reset values in the same cycle; after release a new `i_go` yields `o_src_rst`, then " " as the first byte.
- MSG_LEN=1, SRC_LAT=3: single strobe 6 cycles after `i_go`; no `o_src_adv` ever; `o_done` follows the accept.
